fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current `pc`, issues a request to instruction memory using a req/ack handshake with variable latency, and captures the returned word in the IF/ID pipeline register.
- Drives `pc_advance`, the PC register's load enable, so the PC only moves when a fetch has been accepted.
- Supports decode stall and branch/jump flush.

Parameters:
- `ADDR_W`, 32, width of `pc` and the instruction address.
- `DATA_W`, 32, instruction word width.
- `NOP_WORD`, 32'h00000000, value driven on `ifid_instr` when invalid or after flush.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  ADDR_W  current byte address from the PC register.
- `pc_advance`  out  1  one-cycle pulse; the PC register loads its next value (PCPlus4/branch/jump) when this is high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  ADDR_W  word-aligned fetch address, {pc[ADDR_W-1:2], 2'b00}.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle; only meaningful while `imem_req` is high.
- `imem_rdata`  in  DATA_W  fetched instruction.
- `stall`  in  1  decode cannot accept a new IF/ID entry this cycle.
- `flush`  in  1  redirect (taken branch/jump); the PC register loads its target when `flush` is high, independent of `pc_advance`.
- `ifid_valid`  out  1  IF/ID register holds a live instruction.
- `ifid_instr`  out  DATA_W  registered instruction.
- `ifid_pc`  out  ADDR_W  address of `ifid_instr`.
- `ifid_pcplus4`  out  ADDR_W  `ifid_pc` + 4, wrapping modulo 2^ADDR_W.

Behaviour:
- Reset (async, any time, including mid-handshake):
  - state = IDLE; `imem_req` = 0; `pc_advance` = 0; `ifid_valid` = 0.
  - `ifid_instr` = NOP_WORD; `ifid_pc` = 0; `ifid_pcplus4` = 0; drop flag = 0; hold buffer cleared.
- IDLE: entered only from reset. Moves to REQ on the first clock edge after `rst` deasserts.
- REQ:
  - `imem_req` = 1, `imem_addr` registered from `pc` on entry.
  - `imem_addr` stays stable until `imem_ack`; a request is never withdrawn.
  - On ack with drop = 0 and IF/ID free (`ifid_valid` = 0 or `stall` = 0):
    - load `ifid_instr` = `imem_rdata`, `ifid_pc` = `imem_addr`, `ifid_pcplus4` = `imem_addr` + 4, `ifid_valid` = 1;
    - pulse `pc_advance` in the ack cycle, so the PC updates on the same edge;
    - re-enter REQ, issuing a new request from the updated `pc` on the next cycle;
    - `imem_req` goes low for exactly one cycle between transactions.
  - On ack with drop = 0 and IF/ID busy (`ifid_valid` = 1 and `stall` = 1): latch word and address into the hold buffer and go to HOLD. No `pc_advance`.
  - On ack with drop = 1: discard the word, clear drop, re-enter REQ. No `pc_advance`.
- HOLD:
  - `imem_req` = 0.
  - When `stall` = 0: move the hold buffer into IF/ID, pulse `pc_advance`, go to REQ.
- Decode consumption:
  - While `stall` = 0 and no new entry is loaded in that cycle, `ifid_valid` clears on the next edge.
  - While `stall` = 1, all `ifid_*` outputs hold their values.
- Flush (priority over `stall` and over the load/hold rules above):
  - `ifid_valid` <= 0 and `ifid_instr` <= NOP_WORD on the next edge.
  - In HOLD: the hold buffer is discarded and the state goes to REQ.
  - In REQ without ack: drop <= 1, so the outstanding response is discarded when it arrives.
  - In REQ with ack in the same cycle: the acked word is discarded; drop stays 0.
  - `pc_advance` = 0 in any cycle where `flush` = 1.
  - After a flush, the next request uses the redirected `pc`.
- Throughput: at most one accepted fetch per two cycles (ack cycle plus re-request cycle). `pc_advance` never pulses twice for one fetch.
- Simultaneous `stall` = 1 and `flush` = 1: the flush wins and IF/ID is cleared.

Test Plan:
1. Reset, then single-cycle ack memory (ack in first REQ cycle), `pc` = 0x00000000 advancing by 4 → `imem_addr` sequence 0, 4, 8; `ifid_instr`/`ifid_pc` follow one entry per 2 cycles; `ifid_pcplus4` = 0x4, 0x8, 0xC; one `pc_advance` per fetch.
2. Ack delayed 3 cycles at `pc` = 0x40 → `imem_req` high for 3 cycles with `imem_addr` stable at 0x40; `ifid_pc` = 0x40 only after ack; `pc_advance` only in the ack cycle.
3. `ifid_valid` = 1, `stall` = 1, ack arrives with 0x8C020004 → state HOLD, `ifid_*` unchanged, no `pc_advance`; drop `stall` → `ifid_instr` = 0x8C020004 next edge, one `pc_advance`.
4. `flush` asserted while a 2-cycle-latency request to 0x10 is outstanding, PC redirected to 0x80 → word from 0x10 never reaches IF/ID; next `imem_addr` = 0x80; `ifid_valid` = 0 until that fetch returns.
5. `flush` and `stall` together in HOLD → hold buffer dropped, `ifid_valid` = 0, `ifid_instr` = NOP_WORD, state REQ.
6. `rst` pulsed mid-REQ at `pc` = 0xFFFFFFFC, then `pc` = 0xFFFFFFFC refetched with immediate ack → all outputs zero immediately on reset; after release, `ifid_pcplus4` = 0x00000000 (wrap).

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the instruction-memory req/ack handshake from the PC
// and fills the IF/ID register, with decode stall, redirect flush and a one-entry hold buffer.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_advance,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              flush,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pcplus4
);

  localparam logic [ADDR_W-1:0] INSTR_BYTES = ADDR_W'(32'd4);

  // ST_LAUNCH is the one request-low cycle that lets the PC register settle
  // before its value is captured into imem_addr.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_REQ    = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drop_q, drop_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic [ADDR_W-1:0] ifpc4_q, ifpc4_d;
  logic [DATA_W-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;

  logic              ifid_free_s;
  logic              load_ack_s;
  logic              load_hold_s;
  logic              adv_s;
  logic [ADDR_W-1:0] pc_aligned_s;
  logic              unused_pc_low_s;

  assign pc_aligned_s    = {pc[ADDR_W-1:2], 2'b00};
  assign unused_pc_low_s = ^pc[1:0];

  // Next-state, handshake and IF/ID update logic
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    drop_d       = drop_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    ifpc_d       = ifpc_q;
    ifpc4_d      = ifpc4_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    load_ack_s   = 1'b0;
    load_hold_s  = 1'b0;
    adv_s        = 1'b0;
    ifid_free_s  = !valid_q || !stall;

    case (state_q)
      ST_IDLE, ST_LAUNCH: begin
        // A redirect landing now would make pc stale; wait one more cycle.
        if (flush) begin
          state_d = ST_LAUNCH;
          req_d   = 1'b0;
        end else begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          addr_d  = pc_aligned_s;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          drop_d  = 1'b0;
          state_d = ST_LAUNCH;
          if (flush || drop_q) begin
            load_ack_s = 1'b0;
          end else if (ifid_free_s) begin
            load_ack_s = 1'b1;
            adv_s      = 1'b1;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = addr_q;
            state_d      = ST_HOLD;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          hold_instr_d = NOP_WORD;
          hold_pc_d    = '0;
          state_d      = ST_LAUNCH;
        end else if (!stall) begin
          load_hold_s = 1'b1;
          adv_s       = 1'b1;
          state_d     = ST_LAUNCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        drop_d  = 1'b0;
      end
    endcase

    // IF/ID register: flush beats any load, a load beats consumption
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end else if (load_ack_s) begin
      valid_d = 1'b1;
      instr_d = imem_rdata;
      ifpc_d  = addr_q;
      ifpc4_d = addr_q + INSTR_BYTES;
    end else if (load_hold_s) begin
      valid_d = 1'b1;
      instr_d = hold_instr_q;
      ifpc_d  = hold_pc_q;
      ifpc4_d = hold_pc_q + INSTR_BYTES;
    end else if (!stall) begin
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      drop_q       <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_WORD;
      ifpc_q       <= '0;
      ifpc4_q      <= '0;
      hold_instr_q <= NOP_WORD;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      drop_q       <= drop_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      ifpc_q       <= ifpc_d;
      ifpc4_q      <= ifpc4_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  // pc_advance must be combinational so the PC loads on the very edge that accepts the fetch.
  assign pc_advance   = adv_s;
  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign ifid_valid   = valid_q;
  assign ifid_instr   = instr_q;
  assign ifid_pc      = ifpc_q;
  assign ifid_pcplus4 = ifpc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: PC register and variable-latency memory models,
// with a scoreboard of accepted fetches compared as entries appear in IF/ID.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pcplus4;

  fetch_stage #(.ADDR_W(32), .DATA_W(32), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_advance(pc_advance),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_pcplus4(ifid_pcplus4)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] addr4;
  } entry_t;

  entry_t      exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          adv_cnt  = 0;
  int          pop_cnt  = 0;
  int          lat      = 1;
  logic        mem_on   = 1'b1;
  logic        pc_force = 1'b1;
  logic [31:0] pc_force_val = 32'h0;
  logic [31:0] flush_target = 32'h0;
  logic        ovr_en   = 1'b0;
  logic [31:0] ovr_addr = 32'h0;
  logic [31:0] ovr_data = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] data_for(input logic [31:0] a);
    if (ovr_en && a == ovr_addr) return ovr_data;
    return a ^ 32'hC0DE_0000;
  endfunction

  // PC register model: redirect wins, else advance by 4 on pc_advance
  always @(posedge clk) begin
    if (pc_force) pc <= pc_force_val;
    else if (flush) pc <= flush_target;
    else if (pc_advance) pc <= pc + 32'd4;
  end

  // Memory model: acks in the lat-th cycle of a request
  initial begin
    int cnt;
    cnt = 0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req && mem_on && !rst) begin
        if (cnt >= lat - 1) begin
          imem_ack = 1'b1;
          imem_rdata = data_for(imem_addr);
          cnt = 0;
        end else begin
          imem_ack = 1'b0;
          cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: scoreboard push on accepted ack, pop on each new IF/ID entry
  initial begin
    logic        prev_valid, prev_stall, prev_req, prev_ack, drop_m;
    logic [31:0] prev_addr;
    entry_t      e;
    prev_valid = 1'b0; prev_stall = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
    prev_addr = 32'h0; drop_m = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0; prev_stall = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; drop_m = 1'b0;
      end else begin
        if (pc_advance) adv_cnt++;
        if (flush) check_val("adv_during_flush", 64'(pc_advance), 64'd0);
        if (prev_req && !prev_ack) begin
          check_val("req_not_withdrawn", 64'(imem_req), 64'd1);
          check_val("addr_stable", 64'(imem_addr), 64'(prev_addr));
        end
        if (ifid_valid && (!prev_valid || !prev_stall)) begin
          if (exp_q.size() == 0) begin
            check_val("sb_unexpected_entry", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            pop_cnt++;
            check_val("ifid_instr", 64'(ifid_instr), 64'(e.instr));
            check_val("ifid_pc", 64'(ifid_pc), 64'(e.addr));
            check_val("ifid_pcplus4", 64'(ifid_pcplus4), 64'(e.addr4));
          end
        end
        if (imem_req && imem_ack) begin
          if (!flush && !drop_m) exp_q.push_back({data_for(imem_addr), imem_addr, imem_addr + 32'd4});
          drop_m = 1'b0;
        end else if (imem_req && flush) begin
          drop_m = 1'b1;
        end
        prev_valid = ifid_valid; prev_stall = stall; prev_req = imem_req;
        prev_ack = imem_ack; prev_addr = imem_addr;
      end
    end
  end

  task automatic do_reset(input logic [31:0] pc0, input int latency);
    rst = 1'b1; pc_force = 1'b1; pc_force_val = pc0; stall = 1'b0; flush = 1'b0;
    lat = latency; mem_on = 1'b1; ovr_en = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_val("rst_imem_req", 64'(imem_req), 64'd0);
    check_val("rst_pc_advance", 64'(pc_advance), 64'd0);
    check_val("rst_ifid_valid", 64'(ifid_valid), 64'd0);
    check_val("rst_ifid_instr", 64'(ifid_instr), 64'd0);
    check_val("rst_ifid_pc", 64'(ifid_pc), 64'd0);
    check_val("rst_ifid_pcplus4", 64'(ifid_pcplus4), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; pc_force = 1'b0;
  endtask

  task automatic drain(input string tag);
    @(posedge clk);
    #1;
    stall = 1'b0; flush = 1'b0; mem_on = 1'b0;
    repeat (6) @(negedge clk);
    check_val({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    check_val({tag, "_adv_vs_entries"}, 64'(adv_cnt), 64'(pop_cnt));
  endtask

  task automatic wait_valid(input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      if (ifid_valid) break;
      @(negedge clk);
    end
    check_val(tag, 64'(ifid_valid), 64'd1);
  endtask

  task automatic wait_ack(input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      if (imem_req && imem_ack) break;
      @(negedge clk);
    end
    check_val(tag, 64'(imem_req && imem_ack), 64'd1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;

    // Single-cycle memory: request every other cycle at 0, 4, 8
    do_reset(32'h0000_0000, 1);
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("t1_req_pattern", 64'(imem_req), 64'((i % 2) == 0));
      check_val("t1_adv_pattern", 64'(pc_advance), 64'((i % 2) == 0));
      if ((i % 2) == 0) check_val("t1_addr", 64'(imem_addr), 64'(4 * (i / 2)));
    end
    drain("t1");

    // Three-cycle latency at 0x40
    do_reset(32'h0000_0040, 3);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("t2_req_high", 64'(imem_req), 64'd1);
      check_val("t2_addr", 64'(imem_addr), 64'h40);
      check_val("t2_adv_only_on_ack", 64'(pc_advance), 64'(i == 2));
      check_val("t2_valid_before_ack", 64'(ifid_valid), 64'd0);
    end
    @(negedge clk);
    check_val("t2_valid_after_ack", 64'(ifid_valid), 64'd1);
    check_val("t2_ifid_pc", 64'(ifid_pc), 64'h40);
    drain("t2");

    // Ack while IF/ID busy and stalled goes to the hold buffer
    do_reset(32'h0000_0100, 3);
    stall = 1'b1; ovr_en = 1'b1; ovr_addr = 32'h0000_0104; ovr_data = 32'h8C02_0004;
    wait_valid(20, "t3_first_entry");
    @(negedge clk);
    wait_ack(20, "t3_second_ack");
    check_val("t3_no_adv_busy", 64'(pc_advance), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check_val("t3_hold_req_low", 64'(imem_req), 64'd0);
      check_val("t3_hold_ifid_pc", 64'(ifid_pc), 64'h100);
      check_val("t3_hold_ifid_instr", 64'(ifid_instr), 64'(32'h0000_0100 ^ 32'hC0DE_0000));
    end
    @(posedge clk);
    #1;
    stall = 1'b0;
    @(negedge clk);
    check_val("t3_release_adv", 64'(pc_advance), 64'd1);
    @(negedge clk);
    check_val("t3_release_instr", 64'(ifid_instr), 64'h8C02_0004);
    check_val("t3_release_single_adv", 64'(pc_advance), 64'd0);
    drain("t3");

    // Flush with an outstanding two-cycle request to 0x10, redirect to 0x80
    do_reset(32'h0000_0010, 2);
    flush_target = 32'h0000_0080;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check_val("t4_req_outstanding", 64'(imem_addr), 64'h10);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check_val("t4_valid_c2", 64'(ifid_valid), 64'd0);
    @(negedge clk);
    check_val("t4_gap_req", 64'(imem_req), 64'd0);
    check_val("t4_valid_c3", 64'(ifid_valid), 64'd0);
    @(negedge clk);
    check_val("t4_redirect_req", 64'(imem_req), 64'd1);
    check_val("t4_redirect_addr", 64'(imem_addr), 64'h80);
    check_val("t4_valid_c4", 64'(ifid_valid), 64'd0);
    wait_valid(10, "t4_redirect_entry");
    check_val("t4_ifid_pc", 64'(ifid_pc), 64'h80);
    drain("t4");

    // Flush together with stall while holding
    do_reset(32'h0000_0200, 1);
    stall = 1'b1;
    flush_target = 32'h0000_0300;
    wait_valid(20, "t5_first_entry");
    @(negedge clk);
    wait_ack(20, "t5_second_ack");
    @(negedge clk);
    check_val("t5_in_hold", 64'(imem_req), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk);
    @(posedge clk);
    #1;
    flush = 1'b0; stall = 1'b0;
    @(negedge clk);
    check_val("t5_valid_cleared", 64'(ifid_valid), 64'd0);
    check_val("t5_instr_nop", 64'(ifid_instr), 64'd0);
    for (int k = 0; k < 10; k++) begin
      if (imem_req) break;
      @(negedge clk);
    end
    check_val("t5_req_resumed", 64'(imem_req), 64'd1);
    check_val("t5_redirect_addr", 64'(imem_addr), 64'h300);
    drain("t5");

    // Async reset mid-request at the top of the address space, then wrap
    do_reset(32'hFFFF_FFFC, 4);
    repeat (2) @(negedge clk);
    check_val("t6_mid_req", 64'(imem_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("t6_async_req", 64'(imem_req), 64'd0);
    check_val("t6_async_adv", 64'(pc_advance), 64'd0);
    check_val("t6_async_valid", 64'(ifid_valid), 64'd0);
    check_val("t6_async_instr", 64'(ifid_instr), 64'd0);
    check_val("t6_async_pc", 64'(ifid_pc), 64'd0);
    check_val("t6_async_pcplus4", 64'(ifid_pcplus4), 64'd0);
    do_reset(32'hFFFF_FFFC, 1);
    wait_valid(10, "t6_refetch_entry");
    check_val("t6_ifid_pc", 64'(ifid_pc), 64'hFFFF_FFFC);
    check_val("t6_pcplus4_wrap", 64'(ifid_pcplus4), 64'h0);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
